alu_issue_stage: RTL and testbench

ID/EX issue stage that drives the ALU's operand and operation inputs. It decodes a 32-bit MIPS instruction plus its register-file read values into the 6-bit ALU operation code and the two ALU operands. It also computes the destination register and write enable, and holds everything in a pipeline register with valid, stall and flush control. The outputs connect directly to the ALU's `i_srcA`, `i_srcB` and `i_ALUOp` inputs.

---
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ID/EX issue register that decodes MIPS instructions into ALU ops/operands.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_srcA,
    output logic [31:0] o_srcB,
    output logic [5:0]  o_ALUOp,
    output logic [4:0]  o_rd,
    output logic        o_regwrite,
    output logic        o_illegal
);

    localparam logic [5:0] c_ALU_NOP   = 6'd0;
    localparam logic [5:0] c_ALU_ADD   = 6'd1;
    localparam logic [5:0] c_ALU_SUB   = 6'd2;
    localparam logic [5:0] c_ALU_AND   = 6'd3;
    localparam logic [5:0] c_ALU_OR    = 6'd4;
    localparam logic [5:0] c_ALU_XOR   = 6'd5;
    localparam logic [5:0] c_ALU_NOR   = 6'd6;
    localparam logic [5:0] c_ALU_SRL   = 6'd7;
    localparam logic [5:0] c_ALU_SRA   = 6'd8;
    localparam logic [5:0] c_ALU_SLL   = 6'd9;
    localparam logic [5:0] c_ALU_SLL16 = 6'd10;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [4:0]  w_rt_idx;
    logic [4:0]  w_rd_idx;
    logic [31:0] w_sext;
    logic [31:0] w_zext;

    assign w_op     = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_shamt  = i_instr[10:6];
    assign w_rt_idx = i_instr[20:16];
    assign w_rd_idx = i_instr[15:11];
    assign w_sext   = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_zext   = {16'b0, i_instr[15:0]};

    logic [5:0]  w_aluop;
    logic [31:0] w_srca;
    logic [31:0] w_srcb;
    logic [4:0]  w_rd;
    logic        w_wr;
    logic        w_illegal;

    always_comb begin
        w_aluop   = c_ALU_NOP;
        w_srca    = '0;
        w_srcb    = '0;
        w_rd      = '0;
        w_wr      = 1'b0;
        w_illegal = 1'b0;
        if (w_op == 6'h00) begin
            w_rd = w_rd_idx;
            w_wr = 1'b1;
            case (w_funct)
                6'h20, 6'h21: begin w_aluop = c_ALU_ADD; w_srca = i_rs_data; w_srcb = i_rt_data; end
                6'h22, 6'h23: begin w_aluop = c_ALU_SUB; w_srca = i_rs_data; w_srcb = i_rt_data; end
                6'h24: begin w_aluop = c_ALU_AND; w_srca = i_rs_data; w_srcb = i_rt_data; end
                6'h25: begin w_aluop = c_ALU_OR;  w_srca = i_rs_data; w_srcb = i_rt_data; end
                6'h26: begin w_aluop = c_ALU_XOR; w_srca = i_rs_data; w_srcb = i_rt_data; end
                6'h27: begin w_aluop = c_ALU_NOR; w_srca = i_rs_data; w_srcb = i_rt_data; end
                // Shifts operate on rt; the amount comes from shamt or rs[4:0]
                6'h00: begin w_aluop = c_ALU_SLL; w_srca = i_rt_data; w_srcb = {27'b0, w_shamt}; end
                6'h02: begin w_aluop = c_ALU_SRL; w_srca = i_rt_data; w_srcb = {27'b0, w_shamt}; end
                6'h03: begin w_aluop = c_ALU_SRA; w_srca = i_rt_data; w_srcb = {27'b0, w_shamt}; end
                6'h04: begin w_aluop = c_ALU_SLL; w_srca = i_rt_data; w_srcb = {27'b0, i_rs_data[4:0]}; end
                6'h06: begin w_aluop = c_ALU_SRL; w_srca = i_rt_data; w_srcb = {27'b0, i_rs_data[4:0]}; end
                6'h07: begin w_aluop = c_ALU_SRA; w_srca = i_rt_data; w_srcb = {27'b0, i_rs_data[4:0]}; end
                default: begin w_illegal = 1'b1; w_rd = '0; w_wr = 1'b0; end
            endcase
        end else begin
            w_srca = i_rs_data;
            w_rd   = w_rt_idx;
            w_wr   = 1'b1;
            case (w_op)
                6'h08, 6'h09, 6'h23: begin w_aluop = c_ALU_ADD; w_srcb = w_sext; end
                6'h0C: begin w_aluop = c_ALU_AND; w_srcb = w_zext; end
                6'h0D: begin w_aluop = c_ALU_OR;  w_srcb = w_zext; end
                6'h0E: begin w_aluop = c_ALU_XOR; w_srcb = w_zext; end
                6'h0F: begin w_aluop = c_ALU_SLL16; w_srca = '0; w_srcb = w_zext; end
                6'h2B: begin w_aluop = c_ALU_ADD; w_srcb = w_sext; w_rd = '0; w_wr = 1'b0; end
                6'h04, 6'h05: begin
                    w_aluop = c_ALU_SUB;
                    w_srcb  = i_rt_data;
                    w_rd    = '0;
                    w_wr    = 1'b0;
                end
                default: begin
                    w_illegal = 1'b1;
                    w_srca    = '0;
                    w_rd      = '0;
                    w_wr      = 1'b0;
                end
            endcase
        end
    end

    logic r_valid;
    logic [31:0] r_srca;
    logic [31:0] r_srcb;
    logic [5:0]  r_aluop;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic        r_illegal;

    // An invalid slot loads an all-zero payload so downstream sees a clean bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_srca     <= '0;
            r_srcb     <= '0;
            r_aluop    <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
            r_srca     <= '0;
            r_srcb     <= '0;
            r_aluop    <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (!i_stall) begin
            r_valid    <= i_valid;
            r_srca     <= i_valid ? w_srca : 32'b0;
            r_srcb     <= i_valid ? w_srcb : 32'b0;
            r_aluop    <= i_valid ? w_aluop : c_ALU_NOP;
            r_rd       <= i_valid ? w_rd : 5'b0;
            r_regwrite <= i_valid && w_wr && (w_rd != 5'd0);
            r_illegal  <= i_valid && w_illegal;
        end
    end

    assign o_valid    = r_valid;
    assign o_srcA     = r_srca;
    assign o_srcB     = r_srcb;
    assign o_ALUOp    = r_aluop;
    assign o_rd       = r_rd;
    assign o_regwrite = r_regwrite;
    assign o_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Vector table plus stall/flush/reset sequences for alu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [5:0]  aluop;
        logic [4:0]  rd;
        logic        regwrite;
        logic        illegal;
    } outs_t;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        outs_t       exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        o_valid;
    logic [31:0] o_srcA;
    logic [31:0] o_srcB;
    logic [5:0]  o_ALUOp;
    logic [4:0]  o_rd;
    logic        o_regwrite;
    logic        o_illegal;

    alu_issue_stage dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_instr    (instr),
        .i_rs_data  (rs_data),
        .i_rt_data  (rt_data),
        .i_stall    (stall),
        .i_flush    (flush),
        .o_valid    (o_valid),
        .o_srcA     (o_srcA),
        .o_srcB     (o_srcB),
        .o_ALUOp    (o_ALUOp),
        .o_rd       (o_rd),
        .o_regwrite (o_regwrite),
        .o_illegal  (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t q_exp[$];
    int    n_total = 0;
    int    n_pass  = 0;

    function automatic outs_t mk(logic v, logic [31:0] a, logic [31:0] b, logic [5:0] op,
                                 logic [4:0] rd, logic wr, logic ill);
        outs_t o;
        o.valid = v; o.srca = a; o.srcb = b; o.aluop = op;
        o.rd = rd; o.regwrite = wr; o.illegal = ill;
        return o;
    endfunction

    task automatic check(input string name);
        outs_t act;
        outs_t exp;
        act = {o_valid, o_srcA, o_srcB, o_ALUOp, o_rd, o_regwrite, o_illegal};
        n_total++;
        if (q_exp.size() == 0) begin
            $display("FAIL %s: scoreboard empty, actual %h", name, act);
        end else begin
            exp = q_exp.pop_front();
            if (act !== exp)
                $display("FAIL %s: actual v=%b a=%h b=%h op=%0d rd=%0d wr=%b ill=%b required v=%b a=%h b=%h op=%0d rd=%0d wr=%b ill=%b",
                         name, act.valid, act.srca, act.srcb, act.aluop, act.rd, act.regwrite, act.illegal,
                         exp.valid, exp.srca, exp.srcb, exp.aluop, exp.rd, exp.regwrite, exp.illegal);
            else
                n_pass++;
        end
    endtask

    // Drive on the falling edge, push expectation, sample 1 unit after the rising edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic st, input logic fl,
                        input outs_t exp, input string name);
        @(negedge clk);
        valid = v; instr = ins; rs_data = a; rt_data = b; stall = st; flush = fl;
        q_exp.push_back(exp);
        @(posedge clk);
        #1;
        check(name);
    endtask

    vec_t  vecs[$];
    outs_t zero;
    outs_t add_exp;

    initial begin
        zero = '0;
        vecs.push_back('{"add",   1'b1, 32'h012A4020, 32'd5,        32'd7,        mk(1, 32'd5, 32'd7, 6'd1, 5'd8, 1, 0)});
        vecs.push_back('{"addi",  1'b1, 32'h2062FFFF, 32'd10,       32'd99,       mk(1, 32'd10, 32'hFFFFFFFF, 6'd1, 5'd2, 1, 0)});
        vecs.push_back('{"ori",   1'b1, 32'h3462FFFF, 32'h11,       32'd99,       mk(1, 32'h11, 32'h0000FFFF, 6'd4, 5'd2, 1, 0)});
        vecs.push_back('{"lui",   1'b1, 32'h3C021234, 32'h55,       32'h66,       mk(1, 32'd0, 32'h00001234, 6'd10, 5'd2, 1, 0)});
        vecs.push_back('{"sra",   1'b1, 32'h000520C3, 32'h1,        32'h80000000, mk(1, 32'h80000000, 32'd3, 6'd8, 5'd4, 1, 0)});
        vecs.push_back('{"srlv",  1'b1, 32'h00C52006, 32'h25,       32'hF0,       mk(1, 32'hF0, 32'd5, 6'd7, 5'd4, 1, 0)});
        vecs.push_back('{"ill_op",1'b1, 32'hFC000000, 32'h12,       32'h34,       mk(1, 32'd0, 32'd0, 6'd0, 5'd0, 0, 1)});
        vecs.push_back('{"beq",   1'b1, 32'h11090010, 32'd3,        32'd3,        mk(1, 32'd3, 32'd3, 6'd2, 5'd0, 0, 0)});
        vecs.push_back('{"add_r0",1'b1, 32'h00220020, 32'd1,        32'd2,        mk(1, 32'd1, 32'd2, 6'd1, 5'd0, 0, 0)});
        vecs.push_back('{"nop",   1'b1, 32'h00000000, 32'h77,       32'h12,       mk(1, 32'h12, 32'd0, 6'd9, 5'd0, 0, 0)});
        vecs.push_back('{"sw",    1'b1, 32'hAC450008, 32'd100,      32'h9,        mk(1, 32'd100, 32'd8, 6'd1, 5'd0, 0, 0)});
        vecs.push_back('{"nor",   1'b1, 32'h00221827, 32'hF0F0,     32'h0F0F,     mk(1, 32'hF0F0, 32'h0F0F, 6'd6, 5'd3, 1, 0)});
        vecs.push_back('{"inval", 1'b0, 32'h012A4020, 32'd5,        32'd7,        zero});
        vecs.push_back('{"ill_fn",1'b1, 32'h00221801, 32'd1,        32'd2,        mk(1, 32'd0, 32'd0, 6'd0, 5'd0, 0, 1)});
        vecs.push_back('{"andi",  1'b1, 32'h30278000, 32'hFFFFFFFF, 32'd0,        mk(1, 32'hFFFFFFFF, 32'h00008000, 6'd3, 5'd7, 1, 0)});
        vecs.push_back('{"sllv",  1'b1, 32'h00620804, 32'hFFFFFFE1, 32'd7,        mk(1, 32'd7, 32'd1, 6'd9, 5'd1, 1, 0)});
        vecs.push_back('{"lw",    1'b1, 32'h8C62FFFC, 32'h1000,     32'd0,        mk(1, 32'h1000, 32'hFFFFFFFC, 6'd1, 5'd2, 1, 0)});

        // Reset held with random inputs: outputs must be zero without any edge
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        valid = 1'b1; instr = $urandom; rs_data = $urandom; rt_data = $urandom;
        #3;
        q_exp.push_back(zero);
        check("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0, zero, "post_reset_idle");

        foreach (vecs[i])
            step(vecs[i].valid, vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0, vecs[i].exp, vecs[i].name);

        // ADD held through a 3-cycle stall while SUB waits on the inputs
        add_exp = mk(1, 32'd5, 32'd7, 6'd1, 5'd8, 1, 0);
        step(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b0, 1'b0, add_exp, "stall_load_add");
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h014B4822, 32'd20, 32'd6, 1'b1, 1'b0, add_exp, "stall_hold");
        step(1'b1, 32'h014B4822, 32'd20, 32'd6, 1'b0, 1'b0,
             mk(1, 32'd20, 32'd6, 6'd2, 5'd9, 1, 0), "stall_release_sub");

        step(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b1, 1'b1, zero, "stall_flush_bubble");

        step(1'b0, 32'h012A4020, 32'd5, 32'd7, 1'b1, 1'b0, zero, "stall_hold_bubble");

        // Reset dropped mid-stall clears immediately
        step(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b0, 1'b0, add_exp, "pre_reset_load");
        @(negedge clk);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        q_exp.push_back(zero);
        check("reset_mid_stall");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b1, 1'b0, zero, "post_reset_stall");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
